// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two valid/ready requesters.
// Owns the write-side binary pointer and the registered Gray pointer handed to the read domain.
module fifo_wr_arbiter #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 req0_valid,
  input  logic [DATA_SIZE-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATA_SIZE-1:0] req1_data,
  output logic                 req1_ready,
  input  logic                 wfull,
  output logic                 wclk_en,
  output logic [DATA_SIZE-1:0] wdata,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic [1:0]           owner
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  // One-hot encoding so the grant output is the state register itself.
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

  state_t               r_state;
  logic                 r_last_owner;
  logic [CW-1:0]        r_cnt;
  logic [ADDR_SIZE:0]   r_wbin;
  logic [ADDR_SIZE:0]   r_wptr;

  logic                 w_own0, w_own1;
  logic                 w_xvalid, w_other_valid;
  logic                 w_xfer, w_release;
  logic [ADDR_SIZE:0]   w_wbin_next;
  logic [ADDR_SIZE:0]   w_wgray_next;
  state_t               w_pick;

  assign w_own0        = (r_state == OWN0);
  assign w_own1        = (r_state == OWN1);
  assign req0_ready    = w_own0 & ~wfull;
  assign req1_ready    = w_own1 & ~wfull;
  assign w_xvalid      = w_own1 ? req1_valid : req0_valid;
  assign w_other_valid = w_own1 ? req0_valid : req1_valid;
  assign w_xfer        = (req0_ready & req0_valid) | (req1_ready & req1_valid);
  assign w_release     = (w_own0 | w_own1) &
                         ((w_xfer & (r_cnt == CW'(BURST_LEN-1))) | ~w_xvalid);

  assign w_wbin_next   = r_wbin + {{ADDR_SIZE{1'b0}}, w_xfer};
  assign w_wgray_next  = w_wbin_next ^ (w_wbin_next >> 1);

  // Prefer the requester that did not own the port last; fall back to the other.
  assign w_pick = r_last_owner ? (req0_valid ? OWN0 : OWN1)
                               : (req1_valid ? OWN1 : OWN0);

  assign wclk_en = w_xfer;
  assign wdata   = w_own1 ? req1_data : req0_data;
  assign waddr   = r_wbin[ADDR_SIZE-1:0];
  assign wptr    = r_wptr;
  assign owner   = r_state;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_cnt        <= '0;
      r_wbin       <= '0;
      r_wptr       <= '0;
    end else begin
      r_wbin <= w_wbin_next;
      r_wptr <= w_wgray_next;
      case (r_state)
        IDLE: begin
          if (req0_valid | req1_valid) r_state <= w_pick;
        end
        OWN0, OWN1: begin
          if (w_release) begin
            r_last_owner <= w_own1;
            r_cnt        <= '0;
            // Direct handover when the other side is waiting: no bubble.
            if (w_other_valid) r_state <= w_own1 ? OWN0 : OWN1;
            else               r_state <= IDLE;
          end else if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: bursts, handover, full stall, wrap, reset, forfeit.
module tb_fifo_wr_arbiter;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       wfull;
  logic       wclk_en;
  logic [7:0] wdata;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic [1:0] owner;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.DATA_SIZE(8), .ADDR_SIZE(4), .BURST_LEN(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .wfull(wfull), .wclk_en(wclk_en), .wdata(wdata), .waddr(waddr),
    .wptr(wptr), .owner(owner)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-cycle check; readys only checked where the requester is driving valid.
  task automatic chk_cyc(input string tag, input logic en, input logic [3:0] addr,
                         input logic [1:0] own, input logic [7:0] wd, input logic chk_rdy);
    chk({tag, ".owner"}, owner, own);
    chk({tag, ".en"}, wclk_en, en);
    chk({tag, ".addr"}, waddr, addr);
    if (en) chk({tag, ".wdata"}, wdata, wd);
    if (chk_rdy) begin
      chk({tag, ".rdy0"}, req0_ready, en && own == 2'b01);
      chk({tag, ".rdy1"}, req1_ready, en && own == 2'b10);
    end
  endtask

  task automatic step();
    @(posedge wclk); #1;
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0; wfull = 0;
    wrst_n = 0;
    step();
    wrst_n = 1;
  endtask

  initial begin
    do_reset();
    @(negedge wclk);
    chk("rst.owner", owner, 2'b00);
    chk("rst.rdy0", req0_ready, 0);
    chk("rst.rdy1", req1_ready, 0);
    chk("rst.en", wclk_en, 0);
    chk("rst.addr", waddr, 0);
    chk("rst.wptr", wptr, 0);
    step();

    // 1: req0 alone, 6 samples 0x10..0x15
    req0_valid = 1; req0_data = 8'h10;
    @(negedge wclk); chk_cyc("t1.bub0", 0, 0, 2'b00, 0, 1); step();
    for (int i = 0; i < 4; i++) begin
      req0_data = 8'h10 + 8'(i);
      @(negedge wclk); chk_cyc($sformatf("t1.w%0d", i), 1, 4'(i), 2'b01, req0_data, 1); step();
    end
    @(negedge wclk); chk_cyc("t1.bub1", 0, 4, 2'b00, 0, 1); step();
    for (int i = 4; i < 6; i++) begin
      req0_data = 8'h10 + 8'(i);
      @(negedge wclk); chk_cyc($sformatf("t1.w%0d", i), 1, 4'(i), 2'b01, req0_data, 1); step();
    end
    req0_valid = 0;
    @(negedge wclk); chk_cyc("t1.drop", 0, 6, 2'b01, 0, 0); step();
    @(negedge wclk);
    chk("t1.owner", owner, 2'b00);
    chk("t1.waddr", waddr, 6);
    chk("t1.wptr", wptr, 5'b00101);

    // 2: both valid continuously, alternate bursts of 4 with no bubble at handover
    do_reset();
    req0_valid = 1; req1_valid = 1; req0_data = 8'hA0; req1_data = 8'hB0;
    @(negedge wclk); chk_cyc("t2.bub", 0, 0, 2'b00, 0, 1); step();
    for (int k = 0; k < 12; k++) begin
      logic [1:0] o;
      o = ((k / 4) % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge wclk);
      chk_cyc($sformatf("t2.c%0d", k), 1, 4'(k), o, (o == 2'b01) ? 8'hA0 : 8'hB0, 1);
      step();
    end

    // 3: wfull for 3 cycles after the 2nd write of a req0 burst
    do_reset();
    req0_valid = 1; req1_valid = 1; req0_data = 8'h31; req1_data = 8'h32;
    @(negedge wclk); chk_cyc("t3.bub", 0, 0, 2'b00, 0, 1); step();
    @(negedge wclk); chk_cyc("t3.w0", 1, 0, 2'b01, 8'h31, 1); step();
    @(negedge wclk); chk_cyc("t3.w1", 1, 1, 2'b01, 8'h31, 1); step();
    wfull = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge wclk); chk_cyc($sformatf("t3.full%0d", i), 0, 2, 2'b01, 0, 1); step();
    end
    wfull = 0;
    @(negedge wclk); chk_cyc("t3.w2", 1, 2, 2'b01, 8'h31, 1); step();
    @(negedge wclk); chk_cyc("t3.w3", 1, 3, 2'b01, 8'h31, 1); step();
    @(negedge wclk); chk_cyc("t3.rot", 1, 4, 2'b10, 8'h32, 1); step();

    // 4: 32 transfers, check Gray at wbin=16 and wrap
    do_reset();
    begin
      int n; bit seen;
      n = 0; seen = 0;
      req0_valid = 1; req1_valid = 1;
      for (int c = 0; c < 100 && n < 32; c++) begin
        @(negedge wclk);
        if (wclk_en) n++;
        step();
        if (n == 16 && !seen) begin
          chk("t4.wptr16", wptr, 5'h18);
          seen = 1;
        end
      end
      chk("t4.count", n, 32);
      chk("t4.waddr", waddr, 0);
      chk("t4.wptr", wptr, 0);
    end

    // 5: async reset mid OWN1 burst, then req0 granted first
    do_reset();
    req0_valid = 1; req1_valid = 1; req0_data = 8'h50; req1_data = 8'h51;
    for (int i = 0; i < 7; i++) step();
    @(negedge wclk); chk_cyc("t5.own1", 1, 6, 2'b10, 8'h51, 1);
    step();
    #2 wrst_n = 0;
    #1;
    chk("t5.owner", owner, 0);
    chk("t5.rdy0", req0_ready, 0);
    chk("t5.rdy1", req1_ready, 0);
    chk("t5.en", wclk_en, 0);
    chk("t5.addr", waddr, 0);
    chk("t5.wptr", wptr, 0);
    @(negedge wclk); wrst_n = 1;
    step();
    @(negedge wclk); chk_cyc("t5.first", 1, 0, 2'b01, 8'h50, 1);

    // 6: req0 forfeits mid-burst, req1 continues at next address
    do_reset();
    req0_valid = 1; req1_valid = 1; req0_data = 8'h60; req1_data = 8'h61;
    @(negedge wclk); chk_cyc("t6.bub", 0, 0, 2'b00, 0, 1); step();
    @(negedge wclk); chk_cyc("t6.w0", 1, 0, 2'b01, 8'h60, 1); step();
    @(negedge wclk); chk_cyc("t6.w1", 1, 1, 2'b01, 8'h60, 1); step();
    req0_valid = 0;
    @(negedge wclk); chk_cyc("t6.drop", 0, 2, 2'b01, 0, 0);
    chk("t6.rdy1", req1_ready, 0); step();
    @(negedge wclk); chk_cyc("t6.w2", 1, 2, 2'b10, 8'h61, 1); step();
    @(negedge wclk); chk_cyc("t6.w3", 1, 3, 2'b10, 8'h61, 1); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
